// File: rtl/cpu_datapath.sv
// Bus-based 32-bit CPU datapath: register file, PC/IR/MAR/MDR, Y, 64-bit Z, HI/LO, CON and I/O ports
// sharing one internal bus, with every transfer strobed by the external control unit.
module cpu_datapath (
  input  logic        clk,
  input  logic        clr,
  output logic [31:0] OutPort_output,
  input  logic        IncPC,
  input  logic        CONin,
  input  logic [31:0] Mdatain,
  input  logic [4:0]  opCode,
  input  logic        RAM_write,
  input  logic        MDR_enable,
  input  logic        MDRout,
  input  logic        MAR_enable,
  input  logic        IR_enable,
  input  logic        MDR_read,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        HI_enable,
  input  logic        LO_enable,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        Y_enable,
  input  logic        PC_enable,
  input  logic        OutPort_enable,
  input  logic        InPortout,
  input  logic        PCout,
  input  logic        Yout,
  input  logic        ZLowout,
  input  logic        ZHighout,
  input  logic        LOout,
  input  logic        HIout,
  input  logic        Cout,
  input  logic        BAout,
  input  logic [31:0] InPort_input,
  input  logic        R_in,
  input  logic        R_out,
  input  logic        Cin,
  input  logic        branch_flag
);

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  logic [31:0] r_reg [16];
  logic [31:0] pc_reg, ir_reg, mar_reg, mdr_reg, y_reg, hi_reg, lo_reg;
  logic [31:0] inport_reg, outport_reg;
  logic [63:0] z_reg;
  logic        con_reg;

  logic [3:0]  reg_idx;
  logic [31:0] c_sext, bus;
  logic [63:0] alu_result;
  logic        con_next;

  // MAR feeds the external memory address and RAM_write is consumed off-block.
  logic unused_sig;
  assign unused_sig = ^{RAM_write, mar_reg, ir_reg[31:27]};

  assign reg_idx = (Gra ? ir_reg[26:23] : 4'd0) |
                   (Grb ? ir_reg[22:19] : 4'd0) |
                   (Grc ? ir_reg[18:15] : 4'd0);
  assign c_sext  = {{13{ir_reg[18]}}, ir_reg[18:0]};
  assign OutPort_output = outport_reg;

  always_comb begin
    bus = '0;
    if (R_out || BAout) bus = (BAout && reg_idx == 4'd0) ? '0 : r_reg[reg_idx];
    else if (PCout)     bus = pc_reg;
    else if (MDRout)    bus = mdr_reg;
    else if (ZLowout)   bus = z_reg[31:0];
    else if (ZHighout)  bus = z_reg[63:32];
    else if (HIout)     bus = hi_reg;
    else if (LOout)     bus = lo_reg;
    else if (Yout)      bus = y_reg;
    else if (InPortout) bus = inport_reg;
    else if (Cout)      bus = c_sext;
  end

  // Divider sees a safe divisor; the divide-by-zero result is substituted below.
  logic signed [63:0] mul_a, mul_b, mul_p;
  logic signed [31:0] div_a, div_b, div_q, div_r;
  logic [4:0]         shamt;
  logic [63:0]        rot_r, rot_l;

  assign mul_a = {{32{y_reg[31]}}, y_reg};
  assign mul_b = {{32{bus[31]}}, bus};
  assign mul_p = mul_a * mul_b;
  assign div_a = y_reg;
  assign div_b = (bus == 32'd0) ? 32'sd1 : bus;
  assign div_q = div_a / div_b;
  assign div_r = div_a % div_b;
  assign shamt = bus[4:0];
  assign rot_r = {y_reg, y_reg} >> shamt;
  assign rot_l = {y_reg, y_reg} << shamt;

  always_comb begin
    alu_result = '0;
    if (IncPC) begin
      alu_result = {32'd0, bus + 32'd1};
    end else begin
      case (opCode)
        OP_ADD:  alu_result = {32'd0, y_reg + bus + {31'd0, Cin}};
        OP_SUB:  alu_result = {32'd0, y_reg - bus};
        OP_SHR:  alu_result = {32'd0, y_reg >> shamt};
        OP_SHL:  alu_result = {32'd0, y_reg << shamt};
        OP_ROR:  alu_result = {32'd0, rot_r[31:0]};
        OP_ROL:  alu_result = {32'd0, rot_l[63:32]};
        OP_AND:  alu_result = {32'd0, y_reg & bus};
        OP_OR:   alu_result = {32'd0, y_reg | bus};
        OP_MUL:  alu_result = mul_p;
        OP_DIV:  alu_result = (bus == 32'd0) ? {y_reg, 32'hFFFF_FFFF} : {div_r, div_q};
        OP_NEG:  alu_result = {32'd0, 32'd0 - bus};
        OP_NOT:  alu_result = {32'd0, ~bus};
        default: alu_result = '0;
      endcase
    end
  end

  always_comb begin
    case (ir_reg[20:19])
      2'b00:   con_next = (bus == 32'd0);
      2'b01:   con_next = (bus != 32'd0);
      2'b10:   con_next = ~bus[31];
      default: con_next = bus[31];
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) r_reg[i] <= '0;
      pc_reg      <= '0;
      ir_reg      <= '0;
      mar_reg     <= '0;
      mdr_reg     <= '0;
      y_reg       <= '0;
      z_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      con_reg     <= 1'b0;
      inport_reg  <= '0;
      outport_reg <= '0;
    end else begin
      if (R_in)           r_reg[reg_idx] <= bus;
      if (PC_enable && (!branch_flag || con_reg)) pc_reg <= bus;
      if (IR_enable)      ir_reg      <= bus;
      if (MAR_enable)     mar_reg     <= bus;
      if (MDR_enable)     mdr_reg     <= MDR_read ? Mdatain : bus;
      if (Y_enable)       y_reg       <= bus;
      if (ZHighIn)        z_reg[63:32] <= alu_result[63:32];
      if (ZLowIn)         z_reg[31:0]  <= alu_result[31:0];
      if (HI_enable)      hi_reg      <= bus;
      if (LO_enable)      lo_reg      <= bus;
      if (CONin)          con_reg     <= con_next;
      if (OutPort_enable) outport_reg <= bus;
      inport_reg <= InPort_input;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: every register is observed by routing it over the bus
// into OutPort; expected values are queued at drive time and compared as they emerge.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] OutPort_output;
  logic        IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read;
  logic        Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable;
  logic        OutPort_enable, InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout;
  logic        BAout, R_in, R_out, Cin, branch_flag;
  logic [31:0] Mdatain, InPort_input;
  logic [4:0]  opCode;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .clr(clr), .OutPort_output(OutPort_output), .IncPC(IncPC), .CONin(CONin),
    .Mdatain(Mdatain), .opCode(opCode), .RAM_write(RAM_write), .MDR_enable(MDR_enable),
    .MDRout(MDRout), .MAR_enable(MAR_enable), .IR_enable(IR_enable), .MDR_read(MDR_read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Y_enable(Y_enable), .PC_enable(PC_enable),
    .OutPort_enable(OutPort_enable), .InPortout(InPortout), .PCout(PCout), .Yout(Yout),
    .ZLowout(ZLowout), .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout), .Cout(Cout),
    .BAout(BAout), .InPort_input(InPort_input), .R_in(R_in), .R_out(R_out), .Cin(Cin),
    .branch_flag(branch_flag)
  );

  task automatic idle();
    {IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read} = '0;
    {Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable} = '0;
    {OutPort_enable, InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout} = '0;
    {BAout, R_in, R_out, Cin, branch_flag} = '0;
    opCode = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_mdr(input logic [31:0] v);
    Mdatain = v; MDR_read = 1'b1; MDR_enable = 1'b1;
    tick();
  endtask

  task automatic set_ir(input logic [31:0] v);
    set_mdr(v);
    MDRout = 1'b1; IR_enable = 1'b1;
    tick();
  endtask

  task automatic load_reg(input logic [3:0] idx, input logic [31:0] v);
    set_ir({5'd0, idx, 23'd0});
    set_mdr(v);
    MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1;
    tick();
  endtask

  task automatic set_y(input logic [31:0] v);
    set_mdr(v);
    MDRout = 1'b1; Y_enable = 1'b1;
    tick();
  endtask

  // Caller has already raised the source out-select; route the bus into OutPort and record it.
  task automatic capture(input string n, input logic [31:0] e);
    name_q.push_back(n);
    exp_q.push_back(e);
    OutPort_enable = 1'b1;
    tick();
    got_q.push_back(OutPort_output);
  endtask

  task automatic test_reset();
    logic [31:0] e, g;
    string n;
    idle();
    clr = 1'b0; Mdatain = '0; InPort_input = '0;
    #12;
    total++;
    if (OutPort_output !== 32'd0) begin
      bad++; $display("FAIL reset_outport got=%h want=%h", OutPort_output, 32'd0);
    end else $display("txn reset_outport got=%h", OutPort_output);
    clr = 1'b1;
    @(posedge clk); #1;
    R_out = 1'b1;    capture("r0_reset", 32'd0);
    PCout = 1'b1;    capture("pc_reset", 32'd0);
    Yout = 1'b1;     capture("y_reset", 32'd0);
    ZLowout = 1'b1;  capture("zlo_reset", 32'd0);
    ZHighout = 1'b1; capture("zhi_reset", 32'd0);
    HIout = 1'b1;    capture("hi_reset", 32'd0);
    LOout = 1'b1;    capture("lo_reset", 32'd0);
    set_mdr(32'h0000_5A5A);
    MDRout = 1'b1;   capture("outport_load", 32'h0000_5A5A);
    capture("bus_idle", 32'd0);
    InPort_input = 32'hCAFE_BABE;
    tick();
    InPortout = 1'b1; capture("inport", 32'hCAFE_BABE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, g, e); end
      else $display("txn %s got=%h want=%h", n, g, e);
    end
  endtask

  task automatic test_load_chain();
    logic [31:0] e, g;
    string n;
    logic [3:0]  idx [4] = '{4'd2, 4'd4, 4'd5, 4'd0};
    logic [31:0] val [4] = '{32'h22, 32'h11, 32'h26, 32'h99};
    for (int i = 0; i < 4; i++) load_reg(idx[i], val[i]);
    for (int i = 0; i < 4; i++) begin
      set_ir({5'd0, idx[i], 23'd0});
      Gra = 1'b1; R_out = 1'b1;
      capture($sformatf("r%0d_load", idx[i]), val[i]);
    end
    set_ir(32'd0);
    Gra = 1'b1; BAout = 1'b1; capture("baout_r0", 32'd0);
    set_ir({5'd0, 4'd2, 23'd0});
    Gra = 1'b1; BAout = 1'b1; capture("baout_r2", 32'h22);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, g, e); end
      else $display("txn %s got=%h want=%h", n, g, e);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] e, g;
    string n;
    PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
    tick();
    ZLowout = 1'b1; capture("z_incpc", 32'd1);
    ZLowout = 1'b1; PC_enable = 1'b1;
    tick();
    PCout = 1'b1; capture("pc_fetch", 32'd1);
    set_mdr(32'h4A92_0000);
    MDRout = 1'b1; IR_enable = 1'b1;
    tick();
    Cout = 1'b1; capture("ir_c_field", 32'h0002_0000);
    Gra = 1'b1; R_out = 1'b1; capture("ir_ra_r5", 32'h26);
    Grb = 1'b1; R_out = 1'b1; capture("ir_rb_r2", 32'h22);
    Grc = 1'b1; R_out = 1'b1; capture("ir_rc_r4", 32'h11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, g, e); end
      else $display("txn %s got=%h want=%h", n, g, e);
    end
  endtask

  task automatic test_alu_regs();
    logic [31:0] e, g;
    string n;
    logic [4:0]  ops  [3] = '{5'b00100, 5'b01010, 5'b01001};
    logic [31:0] want [3] = '{32'h11, 32'h33, 32'h00};
    for (int i = 0; i < 3; i++) begin
      Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
      tick();
      Grc = 1'b1; R_out = 1'b1; opCode = ops[i]; ZLowIn = 1'b1;
      tick();
      ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1;
      tick();
      Gra = 1'b1; R_out = 1'b1;
      capture($sformatf("r5_op%05b", ops[i]), want[i]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, g, e); end
      else $display("txn %s got=%h want=%h", n, g, e);
    end
  endtask

  typedef struct packed {
    logic [4:0]  op;
    logic        inc;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } alu_vec_t;

  task automatic test_alu_table();
    logic [31:0] e, g;
    string n;
    alu_vec_t v[$];
    v.push_back('{5'b01110, 1'b0, 1'b0, 32'h22,       32'h11,       32'h242,      32'h0});
    v.push_back('{5'b01110, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 32'hFFFFFFFF});
    v.push_back('{5'b01111, 1'b0, 1'b0, 32'h22,       32'h11,       32'h2,        32'h0});
    v.push_back('{5'b01111, 1'b0, 1'b0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF});
    v.push_back('{5'b01111, 1'b0, 1'b0, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1});
    v.push_back('{5'b01111, 1'b0, 1'b0, 32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234});
    v.push_back('{5'b00111, 1'b0, 1'b0, 32'h80000001, 32'h1,        32'hC0000000, 32'h0});
    v.push_back('{5'b01000, 1'b0, 1'b0, 32'h80000001, 32'h1,        32'h3,        32'h0});
    v.push_back('{5'b00101, 1'b0, 1'b0, 32'h80000001, 32'h1,        32'h40000000, 32'h0});
    v.push_back('{5'b00110, 1'b0, 1'b0, 32'h80000001, 32'h1,        32'h2,        32'h0});
    v.push_back('{5'b00111, 1'b0, 1'b0, 32'h80000001, 32'h20,       32'h80000001, 32'h0});
    v.push_back('{5'b00101, 1'b0, 1'b0, 32'hF0000000, 32'h4,        32'h0F000000, 32'h0});
    v.push_back('{5'b00011, 1'b0, 1'b1, 32'h22,       32'h11,       32'h34,       32'h0});
    v.push_back('{5'b00100, 1'b0, 1'b0, 32'h5,        32'h7,        32'hFFFFFFFE, 32'h0});
    v.push_back('{5'b10000, 1'b0, 1'b0, 32'h9,        32'h1,        32'hFFFFFFFF, 32'h0});
    v.push_back('{5'b10001, 1'b0, 1'b0, 32'h9,        32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0});
    v.push_back('{5'b00000, 1'b0, 1'b0, 32'h5,        32'h6,        32'h0,        32'h0});
    v.push_back('{5'b11111, 1'b0, 1'b0, 32'h5,        32'h6,        32'h0,        32'h0});
    v.push_back('{5'b01110, 1'b1, 1'b0, 32'h2,        32'h5,        32'h6,        32'h0});
    v.push_back('{5'b00000, 1'b1, 1'b0, 32'h2,        32'hFFFFFFFF, 32'h0,        32'h0});
    foreach (v[i]) begin
      set_y(v[i].a);
      set_mdr(v[i].b);
      MDRout = 1'b1; opCode = v[i].op; IncPC = v[i].inc; Cin = v[i].cin;
      ZHighIn = 1'b1; ZLowIn = 1'b1;
      tick();
      ZLowout = 1'b1;  capture($sformatf("alu%0d_op%05b_lo", i, v[i].op), v[i].lo);
      ZHighout = 1'b1; capture($sformatf("alu%0d_op%05b_hi", i, v[i].op), v[i].hi);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, g, e); end
      else $display("txn %s got=%h want=%h", n, g, e);
    end
  endtask

  task automatic test_branch();
    logic [31:0] e, g;
    string n;
    logic [1:0]  mode   [5] = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [31:0] cbus   [5] = '{32'h5, 32'h0, 32'h80000000, 32'h80000000, 32'h0};
    logic [31:0] target [5] = '{32'h40, 32'h80, 32'h50, 32'h60, 32'h70};
    logic [31:0] pc_exp [5] = '{32'h40, 32'h40, 32'h50, 32'h50, 32'h70};
    for (int i = 0; i < 5; i++) begin
      set_ir({11'd0, mode[i], 19'd0});
      set_mdr(cbus[i]);
      MDRout = 1'b1; CONin = 1'b1;
      tick();
      set_mdr(target[i]);
      MDRout = 1'b1; branch_flag = 1'b1; PC_enable = 1'b1;
      tick();
      PCout = 1'b1; capture($sformatf("pc_branch%0d", i), pc_exp[i]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, g, e); end
      else $display("txn %s got=%h want=%h", n, g, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e, g;
    string n;
    load_reg(4'd3, 32'h33);
    set_y(32'h44);
    set_mdr(32'h55); MDRout = 1'b1; HI_enable = 1'b1; tick();
    set_mdr(32'h56); MDRout = 1'b1; LO_enable = 1'b1; tick();
    set_mdr(32'h1);  MDRout = 1'b1; CONin = 1'b1;     tick();
    Gra = 1'b1; R_out = 1'b1; capture("r3_before", 32'h33);
    #3;
    clr = 1'b0;
    #1;
    total++;
    if (OutPort_output !== 32'd0) begin
      bad++; $display("FAIL midreset_outport got=%h want=%h", OutPort_output, 32'd0);
    end else $display("txn midreset_outport got=%h", OutPort_output);
    #2;
    clr = 1'b1;
    @(posedge clk); #1;
    Cout = 1'b1;     capture("ir_cleared", 32'd0);
    PCout = 1'b1;    capture("pc_cleared", 32'd0);
    Yout = 1'b1;     capture("y_cleared", 32'd0);
    HIout = 1'b1;    capture("hi_cleared", 32'd0);
    LOout = 1'b1;    capture("lo_cleared", 32'd0);
    ZLowout = 1'b1;  capture("zlo_cleared", 32'd0);
    ZHighout = 1'b1; capture("zhi_cleared", 32'd0);
    MDRout = 1'b1;   capture("mdr_cleared", 32'd0);
    set_ir({5'd0, 4'd3, 23'd0});
    Gra = 1'b1; R_out = 1'b1; capture("r3_cleared", 32'd0);
    set_mdr(32'h10);
    MDRout = 1'b1; branch_flag = 1'b1; PC_enable = 1'b1;
    tick();
    PCout = 1'b1; capture("con_cleared_pc", 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, g, e); end
      else $display("txn %s got=%h want=%h", n, g, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_chain();
    test_fetch();
    test_alu_regs();
    test_alu_table();
    test_branch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
